ram_sync_scan: RTL and testbench



---
 rtl/ram_sync_pkg.sv | 23 ++
 rtl/ram_sync_scan_counter.sv | 36 +++
 rtl/ram_sync_scan.sv | 74 +++++++
 tb/tb_ram_sync_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_pkg.sv
// Shared constants, word/address types and the reset-contents function for ram_sync_scan.
package ram_sync_pkg;

   localparam int DEF_NBITS_DATA = 4;
   localparam int DEF_NBITS_ADDR = 2;
   localparam int DEF_INIT_STEP  = 3;
   localparam int DEF_SCAN_DIV   = 4;

   typedef logic [DEF_NBITS_DATA-1:0] data_t;
   typedef logic [DEF_NBITS_ADDR-1:0] addr_t;

   // Reset word for entry i: ((i+1)*step) truncated to nbits.
   function automatic logic [31:0] init_word(input int unsigned i,
                                             input int unsigned step,
                                             input int unsigned nbits);
      logic [63:0] prod;
      logic [63:0] mask;
      prod = 64'(i + 1) * 64'(step);
      mask = (64'd1 << nbits) - 64'd1;
      return 32'(prod & mask);
   endfunction

endpackage

// File: rtl/ram_sync_scan_counter.sv
// Scan walker for ram_sync_scan: a SCAN_DIV-cycle prescaler that advances a wrapping address.
module scan_counter
   import ram_sync_pkg::*;
#(
   parameter int NBITS_ADDR = DEF_NBITS_ADDR,
   parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
   input  logic                  clk_2,
   input  logic                  reset_n,
   input  logic                  scan_en,
   output logic [NBITS_ADDR-1:0] scan_addr
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] presc;
   logic          wrap;

   assign wrap = (presc == PW'(SCAN_DIV - 1));

   // Disabling only freezes the walker; position is kept for the next enable.
   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         presc     <= '0;
         scan_addr <= '0;
      end else if (scan_en) begin
         if (wrap) begin
            presc     <= '0;
            scan_addr <= scan_addr + NBITS_ADDR'(1);
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: rtl/ram_sync_scan.sv
// Synchronous lookup memory with registered read, lockable writes and an auto-scan read port.
// Define MEM_WRITE_FIRST_EN to bypass wr_data onto rd_data on a same-address read/write.
module ram_sync_scan
   import ram_sync_pkg::*;
#(
   parameter int NBITS_DATA = DEF_NBITS_DATA,
   parameter int NBITS_ADDR = DEF_NBITS_ADDR,
   parameter int INIT_STEP  = DEF_INIT_STEP,
   parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
   input  logic                  clk_2,
   input  logic                  reset_n,
   input  logic                  rd_en,
   input  logic [NBITS_ADDR-1:0] rd_addr,
   output logic [NBITS_DATA-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  wr_en,
   input  logic [NBITS_ADDR-1:0] wr_addr,
   input  logic [NBITS_DATA-1:0] wr_data,
   input  logic                  wr_lock,
   output logic                  wr_err,
   input  logic                  scan_en,
   output logic [NBITS_ADDR-1:0] scan_addr,
   output logic [NBITS_DATA-1:0] scan_data
);

   localparam int DEPTH = 2 ** NBITS_ADDR;

   logic [NBITS_DATA-1:0] mem [DEPTH];
   logic [NBITS_DATA-1:0] rd_word;
   logic                  wr_do;

   assign wr_do = wr_en && !wr_lock;

`ifdef MEM_WRITE_FIRST_EN
   assign rd_word = (wr_do && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
   assign rd_word = mem[rd_addr];
`endif

   scan_counter #(
      .NBITS_ADDR (NBITS_ADDR),
      .SCAN_DIV   (SCAN_DIV)
   ) u_scan (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .scan_en   (scan_en),
      .scan_addr (scan_addr)
   );

   // Reset reloads the default table and drops any read or write presented in that cycle.
   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= NBITS_DATA'(init_word(int'(i), int'(INIT_STEP), int'(NBITS_DATA)));
         end
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         wr_err    <= 1'b0;
         scan_data <= NBITS_DATA'(init_word(0, int'(INIT_STEP), int'(NBITS_DATA)));
      end else begin
         if (wr_do) begin
            mem[wr_addr] <= wr_data;
         end
         wr_err   <= wr_en && wr_lock;
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_word;
         end
         scan_data <= mem[scan_addr];
      end
   end

endmodule

// File: tb/tb_ram_sync_scan.sv
// Directed bench for ram_sync_scan: cycle model of the memory checked every cycle, plus literal checkpoints.
module tb_ram_sync_scan;
   import ram_sync_pkg::*;

   localparam int ND    = 4;
   localparam int NA    = 2;
   localparam int STEP  = 3;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;

   logic  clk_2 = 1'b0;
   logic  reset_n;
   logic  rd_en;
   addr_t rd_addr;
   data_t rd_data;
   logic  rd_valid;
   logic  wr_en;
   addr_t wr_addr;
   data_t wr_data;
   logic  wr_lock;
   logic  wr_err;
   logic  scan_en;
   addr_t scan_addr;
   data_t scan_data;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // model state
   int m_mem [DEPTH];
   int m_rd_data;
   int m_rd_valid;
   int m_wr_err;
   int m_scan_data;
   int m_en_cnt;

   int lit_rd [4]  = '{3, 6, 9, 12};
   int lit_sa [17] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0};
   int lit_sd [17] = '{3, 3, 3, 3, 6, 6, 6, 6, 9, 9, 9, 9, 12, 12, 12, 12, 3};

   always #5 clk_2 = ~clk_2;

   ram_sync_scan #(
      .NBITS_DATA (ND),
      .NBITS_ADDR (NA),
      .INIT_STEP  (STEP),
      .SCAN_DIV   (DIV)
   ) dut (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_lock   (wr_lock),
      .wr_err    (wr_err),
      .scan_en   (scan_en),
      .scan_addr (scan_addr),
      .scan_data (scan_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_scan_addr();
      return (m_en_cnt / DIV) % DEPTH;
   endfunction

   // Model: inputs are stable at the rising edge, so it evaluates them there using pre-edge state.
   always @(posedge clk_2) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = ((i + 1) * STEP) % (1 << ND);
         m_rd_data   = 0;
         m_rd_valid  = 0;
         m_wr_err    = 0;
         m_en_cnt    = 0;
         m_scan_data = m_mem[0];
      end else begin
         m_scan_data = m_mem[m_scan_addr()];
         if (rd_en) begin
            m_rd_data = m_mem[rd_addr];
`ifdef MEM_WRITE_FIRST_EN
            if (wr_en && !wr_lock && wr_addr == rd_addr) m_rd_data = int'(wr_data);
`endif
         end
         m_rd_valid = rd_en ? 1 : 0;
         m_wr_err   = (wr_en && wr_lock) ? 1 : 0;
         if (wr_en && !wr_lock) m_mem[wr_addr] = int'(wr_data);
         if (scan_en) m_en_cnt++;
      end
   end

   always @(negedge clk_2) begin
      if (chk_on) begin
         chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
         chk("rd_data", 32'(rd_data), 32'(m_rd_data));
         chk("wr_err", 32'(wr_err), 32'(m_wr_err));
         chk("scan_addr", 32'(scan_addr), 32'(m_scan_addr()));
         chk("scan_data", 32'(scan_data), 32'(m_scan_data));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
      wr_data = '0; wr_lock = 1'b0; scan_en = 1'b0;
      @(negedge clk_2);
      @(negedge clk_2);
      chk_on = 1'b1;
      reset_n = 1'b1;

      // reset contents, back-to-back reads
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1; rd_addr = addr_t'(i);
         @(negedge clk_2);
         chk("lit_reset_read", 32'(rd_data), 32'(lit_rd[i]));
         chk("lit_reset_valid", 32'(rd_valid), 32'd1);
      end
      rd_en = 1'b0;
      @(negedge clk_2);
      chk("lit_idle_valid", 32'(rd_valid), 32'd0);
      chk("lit_idle_hold", 32'(rd_data), 32'd12);
      chk("lit_scan_idle", 32'(scan_data), 32'd3);

      // write then read
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hF;
      @(negedge clk_2);
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 2'd1;
      @(negedge clk_2);
      chk("lit_write_read", 32'(rd_data), 32'd15);
      rd_en = 1'b0;

      // locked write
      wr_en = 1'b1; wr_lock = 1'b1; wr_addr = 2'd2; wr_data = 4'h0;
      @(negedge clk_2);
      chk("lit_lock_err", 32'(wr_err), 32'd1);
      wr_en = 1'b0; wr_lock = 1'b0;
      @(negedge clk_2);
      chk("lit_lock_err_clear", 32'(wr_err), 32'd0);
      rd_en = 1'b1; rd_addr = 2'd2;
      @(negedge clk_2);
      chk("lit_lock_read", 32'(rd_data), 32'd9);

      // same-address collision
      rd_en = 1'b1; rd_addr = 2'd3; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd5;
      @(negedge clk_2);
`ifdef MEM_WRITE_FIRST_EN
      chk("lit_collide", 32'(rd_data), 32'd5);
`else
      chk("lit_collide", 32'(rd_data), 32'd12);
`endif
      wr_en = 1'b0; rd_addr = 2'd3;
      @(negedge clk_2);
      chk("lit_collide_after", 32'(rd_data), 32'd5);

      // different-address read/write in one cycle
      rd_addr = 2'd0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd7;
      @(negedge clk_2);
      chk("lit_diff_addr", 32'(rd_data), 32'd3);
      wr_en = 1'b0; rd_addr = 2'd2;
      @(negedge clk_2);
      chk("lit_diff_addr_wr", 32'(rd_data), 32'd7);
      rd_en = 1'b0;

      // scan from a fresh reset
      reset_n = 1'b0;
      @(negedge clk_2);
      reset_n = 1'b1; scan_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_2);
         if (k <= 17) begin
            chk("lit_scan_addr", 32'(scan_addr), 32'(lit_sa[k-1]));
            chk("lit_scan_data", 32'(scan_data), 32'(lit_sd[k-1]));
         end
      end
      scan_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_2);
         chk("lit_scan_freeze", 32'(scan_addr), 32'd1);
      end

      // write to the scanned address shows up one cycle after the write edge
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hB;
      @(negedge clk_2);
      chk("lit_scan_wr_old", 32'(scan_data), 32'd6);
      wr_en = 1'b0;
      @(negedge clk_2);
      chk("lit_scan_wr_new", 32'(scan_data), 32'd11);

      // reset mid-scan
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hA;
      @(negedge clk_2);
      wr_en = 1'b0; scan_en = 1'b1;
      for (int k = 0; k < 4; k++) @(negedge clk_2);
      chk("lit_scan_at2", 32'(scan_addr), 32'd2);
      reset_n = 1'b0; rd_en = 1'b1; rd_addr = 2'd1;
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd0;
      @(negedge clk_2);
      chk("lit_rst_scan_addr", 32'(scan_addr), 32'd0);
      chk("lit_rst_scan_data", 32'(scan_data), 32'd3);
      chk("lit_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("lit_rst_rd_data", 32'(rd_data), 32'd0);
      reset_n = 1'b1; scan_en = 1'b0; wr_en = 1'b0; rd_addr = 2'd0;
      @(negedge clk_2);
      chk("lit_rst_mem0", 32'(rd_data), 32'd3);
      rd_addr = 2'd3;
      @(negedge clk_2);
      chk("lit_rst_wr_dropped", 32'(rd_data), 32'd12);
      rd_en = 1'b0;
      @(negedge clk_2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
